// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the accumulator CPU datapath (ir, pc, acc, alu, mux_a/b/c).
// Fetches, bumps PC and executes one instruction at a time, with memory timeout and run/step/halt control.
module cpu_sequencer #(
   parameter int               ALU_W     = 5,
   parameter int               TIMEOUT   = 16,
   parameter logic [ALU_W-1:0] ALU_PASSA = 5'd0,
   parameter logic [ALU_W-1:0] ALU_PASSB = 5'd1,
   parameter logic [ALU_W-1:0] ALU_ADD   = 5'd2,
   parameter logic [ALU_W-1:0] ALU_SUB   = 5'd3,
   parameter logic [ALU_W-1:0] ALU_AND   = 5'd4,
   parameter logic [ALU_W-1:0] ALU_OR    = 5'd5,
   parameter logic [ALU_W-1:0] ALU_XOR   = 5'd6,
   parameter logic [ALU_W-1:0] ALU_INC   = 5'd7
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       ir_op,
   input  logic             carry,
   input  logic             zero,
   input  logic             mem_rdy,
   input  logic             run,
   input  logic             step,
   output logic             mem_req,
   output logic             rw,
   output logic [ALU_W-1:0] alu,
   output logic             muxa,
   output logic             muxb,
   output logic             muxc,
   output logic             en_ir,
   output logic             en_pc,
   output logic             en_da,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err
);

   localparam logic [2:0] S_HALT  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_INCPC = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_MEM   = 3'd4;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_LDM  = 8'h02;
   localparam logic [7:0] OP_STM  = 8'h03;
   localparam logic [7:0] OP_ADDI = 8'h04;
   localparam logic [7:0] OP_ADDM = 8'h05;
   localparam logic [7:0] OP_SUBM = 8'h06;
   localparam logic [7:0] OP_ANDM = 8'h07;
   localparam logic [7:0] OP_ORM  = 8'h08;
   localparam logic [7:0] OP_XORM = 8'h09;
   localparam logic [7:0] OP_JMP  = 8'h0A;
   localparam logic [7:0] OP_JZ   = 8'h0B;
   localparam logic [7:0] OP_JC   = 8'h0C;
   localparam logic [7:0] OP_HALT = 8'h0D;

   // The counter only ever holds 0..TIMEOUT-1; the final wait cycle aborts instead of counting.
   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_c_q, flag_c_d;
   logic             bus_err_q, bus_err_d;
   logic             single_q, single_d;
   logic             run_q, step_q;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   logic             run_rise_s;
   logic             step_rise_s;
   logic             wait_last_s;
   logic [2:0]       done_state_s;

   function automatic logic [ALU_W-1:0] mem_alu(input logic [7:0] op);
      case (op)
         OP_LDM:  return ALU_PASSB;
         OP_ADDM: return ALU_ADD;
         OP_SUBM: return ALU_SUB;
         OP_ANDM: return ALU_AND;
         OP_ORM:  return ALU_OR;
         OP_XORM: return ALU_XOR;
         default: return ALU_PASSA;
      endcase
   endfunction

   assign run_rise_s   = run & ~run_q;
   assign step_rise_s  = step & ~step_q;
   assign wait_last_s  = (TIMEOUT != 0) && !mem_rdy && (tmo_cnt_q == TMO_LAST);
   assign done_state_s = (run && !single_q) ? S_FETCH : S_HALT;
   assign halted       = (state_q == S_HALT);
   assign bus_err      = bus_err_q;

   // Next-state, datapath control decode, flag capture and timeout counting
   always_comb begin
      state_d   = state_q;
      single_d  = single_q;
      bus_err_d = bus_err_q;
      mem_req   = 1'b0;
      rw        = 1'b1;
      alu       = ALU_PASSA;
      muxa      = 1'b0;
      muxb      = 1'b0;
      muxc      = 1'b0;
      en_ir     = 1'b0;
      en_pc     = 1'b0;
      en_da     = 1'b0;
      illegal   = 1'b0;

      case (state_q)
         S_HALT: begin
            if (step_rise_s) begin
               state_d   = S_FETCH;
               single_d  = 1'b1;
               bus_err_d = 1'b0;
            end else if (run_rise_s) begin
               state_d   = S_FETCH;
               single_d  = 1'b0;
               bus_err_d = 1'b0;
            end else begin
               state_d = S_HALT;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_rdy) begin
               en_ir   = 1'b1;
               state_d = S_INCPC;
            end else if (wait_last_s) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_INCPC: begin
            muxa    = 1'b1;
            alu     = ALU_INC;
            en_pc   = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = done_state_s;
            case (ir_op)
               OP_NOP: state_d = done_state_s;
               OP_LDI: begin
                  muxb  = 1'b1;
                  alu   = ALU_PASSB;
                  en_da = 1'b1;
               end
               OP_ADDI: begin
                  muxb  = 1'b1;
                  alu   = ALU_ADD;
                  en_da = 1'b1;
               end
               OP_LDM, OP_STM, OP_ADDM, OP_SUBM, OP_ANDM, OP_ORM, OP_XORM: state_d = S_MEM;
               OP_JMP: begin
                  muxb  = 1'b1;
                  alu   = ALU_PASSB;
                  en_pc = 1'b1;
               end
               OP_JZ: begin
                  if (flag_z_q) begin
                     muxb  = 1'b1;
                     alu   = ALU_PASSB;
                     en_pc = 1'b1;
                  end else begin
                     state_d = done_state_s;
                  end
               end
               OP_JC: begin
                  if (flag_c_q) begin
                     muxb  = 1'b1;
                     alu   = ALU_PASSB;
                     en_pc = 1'b1;
                  end else begin
                     state_d = done_state_s;
                  end
               end
               OP_HALT: state_d = S_HALT;
               default: illegal = 1'b1;
            endcase
         end
         S_MEM: begin
            // Stores push the accumulator out through the ALU pass-through
            mem_req = 1'b1;
            muxc    = 1'b1;
            alu     = mem_alu(ir_op);
            rw      = (ir_op != OP_STM);
            if (mem_rdy) begin
               en_da   = (ir_op != OP_STM);
               state_d = done_state_s;
            end else if (wait_last_s) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               state_d = S_MEM;
            end
         end
         default: state_d = S_HALT;
      endcase

      flag_z_d = en_da ? zero  : flag_z_q;
      flag_c_d = en_da ? carry : flag_c_q;

      if (mem_req && !mem_rdy && (state_d == state_q)) begin
         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end else begin
         tmo_cnt_d = '0;
      end
   end

   // Sequencer state, flags, status and input edge-detect registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= S_HALT;
         flag_z_q  <= 1'b0;
         flag_c_q  <= 1'b0;
         bus_err_q <= 1'b0;
         single_q  <= 1'b0;
         run_q     <= 1'b0;
         step_q    <= 1'b0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         flag_z_q  <= flag_z_d;
         flag_c_q  <= flag_c_d;
         bus_err_q <= bus_err_d;
         single_q  <= single_d;
         run_q     <= run;
         step_q    <= step;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, hand-built corner sequences,
// and random instruction streams checked against an instruction-level expected-trace model.
module tb_cpu_sequencer;

   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       clr;
   logic [7:0] ir_op;
   logic       carry, zero, mem_rdy, run, step;
   logic       mem_req, rw, muxa, muxb, muxc, en_ir, en_pc, en_da, halted, illegal, bus_err;
   logic [4:0] alu;

   cpu_sequencer #(.ALU_W(5), .TIMEOUT(TMO)) dut (
      .clk(clk), .clr(clr), .ir_op(ir_op), .carry(carry), .zero(zero), .mem_rdy(mem_rdy),
      .run(run), .step(step), .mem_req(mem_req), .rw(rw), .alu(alu), .muxa(muxa),
      .muxb(muxb), .muxc(muxc), .en_ir(en_ir), .en_pc(en_pc), .en_da(en_da),
      .halted(halted), .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   logic [15:0] act;
   assign act = {mem_req, rw, alu, muxa, muxb, muxc, en_ir, en_pc, en_da, halted, illegal, bus_err};

   int   errors = 0;
   int   checks = 0;
   int   cyc_n  = 0;
   int   drop_cnt = -1;
   logic m_z = 1'b0, m_c = 1'b0, m_berr = 1'b0, m_single = 1'b0, run_lvl = 1'b0;
   logic fix_zc = 1'b0, fz = 1'b0, fc = 1'b0;

   typedef struct {
      logic [7:0]  op;
      logic        rdy, z, c, r, s;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[8];

   function automatic logic [15:0] ex(input logic mreq, input logic rwv, input logic [4:0] a,
                                      input logic ma, input logic mb, input logic mc,
                                      input logic eir, input logic epc, input logic eda,
                                      input logic hlt, input logic ill, input logic be);
      return {mreq, rwv, a, ma, mb, mc, eir, epc, eda, hlt, ill, be};
   endfunction

   function automatic logic [15:0] o_halt(input logic be);
      return ex(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, be);
   endfunction
   function automatic logic [15:0] o_fetch(input logic rdy, input logic be);
      return ex(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, be);
   endfunction
   function automatic logic [15:0] o_inc(input logic be);
      return ex(1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, be);
   endfunction
   function automatic logic [15:0] o_nop(input logic be);
      return ex(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, be);
   endfunction

   task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc_n, a, e);
      end
   endtask

   task automatic drive_check(input logic [7:0] op, input logic rdy, input logic z, input logic c,
                              input logic r, input logic s, input logic [15:0] e, input string nm);
      @(negedge clk);
      ir_op = op; mem_rdy = rdy; zero = z; carry = c; run = r; step = s;
      #1;
      check(nm, act, e);
      if (e[3]) begin
         m_z = z;
         m_c = c;
      end
      cyc_n++;
   endtask

   task automatic cyc(input logic [7:0] op, input logic rdy, input logic [15:0] e, input string nm);
      logic z, c;
      z = fix_zc ? fz : 1'($urandom);
      c = fix_zc ? fc : 1'($urandom);
      if (drop_cnt == 0) run_lvl = 1'b0;
      if (drop_cnt >= 0) drop_cnt--;
      drive_check(op, rdy, z, c, run_lvl, 1'b0, e, nm);
   endtask

   // Leave HALT with a run and/or step rising edge (always preceded by a quiet cycle).
   task automatic start(input logic r, input logic s);
      drive_check(8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, o_halt(m_berr), "halt_idle");
      drive_check(8'($urandom), 1'($urandom), 1'b0, 1'b0, r, s, o_halt(m_berr), "halt_edge");
      m_berr = 1'b0;
      m_single = s;
      run_lvl = r;
   endtask

   // One whole instruction: fw/mw are wait cycles before mem_rdy in fetch and memory phases.
   task automatic instr(input logic [7:0] op, input int fw, input int mw, output logic halts);
      logic        rdy, jmp, is_mem, st;
      logic [4:0]  ma;
      logic [15:0] e;
      halts = 1'b1;
      for (int i = 0; i <= fw; i++) begin
         rdy = (i == fw);
         cyc(8'($urandom), rdy, o_fetch(rdy, m_berr), "fetch");
         if (!rdy && (i + 1 == TMO)) begin
            m_berr = 1'b1;
            return;
         end
      end
      cyc(op, 1'($urandom), o_inc(m_berr), "incpc");
      jmp = (op == 8'h0A) || (op == 8'h0B && m_z) || (op == 8'h0C && m_c);
      is_mem = (op >= 8'h02) && (op <= 8'h09) && (op != 8'h04);
      if (op == 8'h01 || op == 8'h04)
         e = ex(1'b0, 1'b1, (op == 8'h01) ? 5'd1 : 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_berr);
      else if (jmp)
         e = ex(1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_berr);
      else if (op <= 8'h0D)
         e = o_nop(m_berr);
      else
         e = ex(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_berr);
      cyc(op, 1'($urandom), e, "exec");
      if (is_mem) begin
         st = (op == 8'h03);
         ma = (op == 8'h02) ? 5'd1 : st ? 5'd0 : 5'(op - 8'd3);
         for (int i = 0; i <= mw; i++) begin
            rdy = (i == mw);
            cyc(op, rdy, ex(1'b1, !st, ma, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rdy && !st, 1'b0, 1'b0, m_berr), "mem");
            if (!rdy && (i + 1 == TMO)) begin
               m_berr = 1'b1;
               return;
            end
         end
      end
      halts = (op == 8'h0D) || !run_lvl || m_single;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       h;
      logic [7:0] op;
      int         k, mode, fw, mw;

      clr = 1'b0; ir_op = 8'h00; carry = 1'b0; zero = 1'b0; mem_rdy = 1'b0; run = 1'b0; step = 1'b0;

      tbl[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, o_halt(1'b0)};
      tbl[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, o_fetch(1'b1, 1'b0)};
      tbl[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, o_inc(1'b0)};
      tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                 ex(1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
      tbl[4] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, o_fetch(1'b1, 1'b0)};
      tbl[5] = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, o_inc(1'b0)};
      tbl[6] = '{8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                 ex(1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
      tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o_halt(1'b0)};

      #1;
      check("reset_outputs", act, o_halt(1'b0));
      repeat (2) @(negedge clk);
      #2 clr = 1'b1;

      // LDI then ADDI from a run edge, run released during the final EXEC
      for (int i = 0; i < 8; i++)
         drive_check(tbl[i].op, tbl[i].rdy, tbl[i].z, tbl[i].c, tbl[i].r, tbl[i].s, tbl[i].exp, "table");

      // Delayed LDM, STM, SUBM/JZ taken and not taken, illegal, HALT opcode with run high
      start(1'b1, 1'b0);
      instr(8'h02, 0, 3, h);
      instr(8'h03, 1, 0, h);
      fix_zc = 1'b1; fz = 1'b1; fc = 1'b0;
      instr(8'h06, 0, 0, h);
      fix_zc = 1'b0;
      instr(8'h0B, 0, 0, h);
      fix_zc = 1'b1; fz = 1'b0; fc = 1'b1;
      instr(8'h06, 0, 1, h);
      fix_zc = 1'b0;
      instr(8'h0B, 0, 0, h);
      instr(8'h0C, 0, 0, h);
      instr(8'hFF, 0, 0, h);
      instr(8'h0D, 0, 0, h);
      for (int i = 0; i < 3; i++)
         drive_check(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, o_halt(1'b0), "halt_hold");

      // Fetch timeout, then a step edge clears bus_err and runs exactly one instruction
      start(1'b1, 1'b0);
      instr(8'h01, 40, 0, h);
      start(1'b0, 1'b1);
      instr(8'h04, 0, 0, h);
      drive_check(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o_halt(1'b0), "single_done");

      // Simultaneous run and step edges: single step wins even with run held high
      start(1'b1, 1'b1);
      instr(8'h0A, 0, 0, h);
      drive_check(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, o_halt(1'b0), "step_wins");

      // Memory-phase timeout, then run dropped mid-instruction
      start(1'b1, 1'b0);
      instr(8'h05, 0, 30, h);
      start(1'b1, 1'b0);
      drop_cnt = 2;
      instr(8'h02, 1, 2, h);
      drop_cnt = -1;
      drive_check(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o_halt(1'b0), "run_drop");

      // Asynchronous reset while the PC increment is being driven
      start(1'b1, 1'b0);
      cyc(8'h00, 1'b1, o_fetch(1'b1, m_berr), "fetch");
      cyc(8'h01, 1'b1, o_inc(m_berr), "incpc");
      #1 clr = 1'b0;
      #1 check("reset_abort", act, o_halt(1'b0));
      run = 1'b0;
      m_z = 1'b0; m_c = 1'b0; m_berr = 1'b0; run_lvl = 1'b0;
      @(negedge clk);
      #2 clr = 1'b1;
      start(1'b1, 1'b0);
      instr(8'h0B, 0, 0, h);
      instr(8'h0C, 0, 0, h);

      // Random instruction streams with random waits, timeouts, run drops and restarts
      h = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (h) begin
            mode = $urandom_range(0, 3);
            start(mode != 0, mode <= 1);
         end
         k = $urandom_range(0, 15);
         op = (k <= 13) ? 8'(k) : 8'($urandom_range(14, 255));
         fw = ($urandom_range(0, 24) == 0) ? 20 : $urandom_range(0, 3);
         mw = ($urandom_range(0, 24) == 0) ? 20 : $urandom_range(0, 3);
         drop_cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
         instr(op, fw, mw, h);
         drop_cnt = -1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
